// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: funct codes, FSM and op encodings,
// and the ALU control codes also used by alu_control.
package muldiv_sequencer_pkg;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PREP  = 2'd1,
    S_ITER  = 2'd2,
    S_FIXUP = 2'd3
  } md_state_e;

  // Encoding matches funct[1:0] of the MULT/MULTU/DIV/DIVU group.
  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } md_op_e;

  function automatic logic is_md_funct(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  function automatic logic is_hilo_funct(input logic [5:0] f);
    return is_md_funct(f) || (f == F_MFHI) || (f == F_MTHI) ||
           (f == F_MFLO) || (f == F_MTLO);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] work,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_n,
  output logic [WIDTH-1:0] work_n
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;
  logic           ge;

  always_comb begin
    sum    = {1'b0, acc} + (work[0] ? {1'b0, opnd} : '0);
    rem_sh = {acc, work[WIDTH-1]};
    trial  = rem_sh - {1'b0, opnd};
    // A set top bit of the shifted remainder already exceeds any divisor.
    ge     = rem_sh[WIDTH] | ~trial[WIDTH];
    if (is_div) begin
      acc_n  = ge ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      work_n = {work[WIDTH-2:0], ge};
    end else begin
      acc_n  = sum[WIDTH:1];
      work_n = {sum[0], work[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine owning HI/LO; serves MFHI/MFLO/MTHI/MTLO.
// Optional MULDIV_EARLY_EXIT_EN: multiplies exit once remaining multiplier bits are zero.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_data
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  md_state_e          state_q, state_d;
  md_op_e             op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               is_div;
  logic               sgn_op;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   step_acc, step_work;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

`ifdef MULDIV_EARLY_EXIT_EN
  logic [CNT_W-1:0]   rem_bits;
  logic [WIDTH-1:0]   rem_mask;
  logic [2*WIDTH-1:0] aligned;
`endif

  assign is_div   = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign sgn_op   = (op_q == OP_MULT) || (op_q == OP_DIV);
  // During PREP work/opnd still hold raw rs/rt.
  assign mag_a    = (sgn_op && work_q[WIDTH-1]) ? -work_q : work_q;
  assign mag_b    = (sgn_op && opnd_q[WIDTH-1]) ? -opnd_q : opnd_q;
  assign prod     = {acc_q, work_q};
  assign prod_fix = (sa_q ^ sb_q) ? -prod : prod;
  assign quo_fix  = (sa_q ^ sb_q) ? -work_q : work_q;
  assign rem_fix  = sa_q ? -acc_q : acc_q;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div),
    .acc    (acc_q),
    .work   (work_q),
    .opnd   (opnd_q),
    .acc_n  (step_acc),
    .work_n (step_work)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    work_d  = work_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    done_d  = 1'b0;
`ifdef MULDIV_EARLY_EXIT_EN
    rem_bits = cnt_q - CNT_W'(1);
    rem_mask = ~({WIDTH{1'b1}} << rem_bits);
    aligned  = {step_acc, step_work} >> rem_bits;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (op_valid && !flush) begin
          if (funct == F_MTHI) begin
            hi_d = rs_data;
          end else if (funct == F_MTLO) begin
            lo_d = rs_data;
          end else if (is_md_funct(funct)) begin
            if (funct[1] && (rt_data == '0)) begin
              lo_d   = '1;
              hi_d   = rs_data;
              done_d = 1'b1;
            end else begin
              op_d    = md_op_e'(funct[1:0]);
              work_d  = rs_data;
              opnd_d  = rt_data;
              state_d = S_PREP;
            end
          end
        end
      end
      S_PREP: begin
        sa_d    = sgn_op & work_q[WIDTH-1];
        sb_d    = sgn_op & opnd_q[WIDTH-1];
        acc_d   = '0;
        work_d  = is_div ? mag_a : mag_b;
        opnd_d  = is_div ? mag_b : mag_a;
        cnt_d   = CNT_W'(WIDTH);
        state_d = S_ITER;
      end
      S_ITER: begin
        acc_d  = step_acc;
        work_d = step_work;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIXUP;
`ifdef MULDIV_EARLY_EXIT_EN
        // Unprocessed multiplier bits sit in the low rem_bits of work; if all zero the
        // remaining steps are pure shifts, so apply them in one go.
        if (!is_div && ((step_work & rem_mask) == '0)) begin
          acc_d   = aligned[2*WIDTH-1:WIDTH];
          work_d  = aligned[WIDTH-1:0];
          cnt_d   = '0;
          state_d = S_FIXUP;
        end
`endif
      end
      S_FIXUP: begin
        hi_d    = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo_d    = is_div ? quo_fix : prod_fix[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULT;
      cnt_q   <= '0;
      acc_q   <= '0;
      work_q  <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      work_q  <= work_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign stall   = busy_q & op_valid & is_hilo_funct(funct);
  assign mf_data = (op_valid && funct == F_MFHI) ? hi_q :
                   (op_valid && funct == F_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: arithmetic reference model feeds an expectation
// queue that a negedge monitor drains whenever done pulses.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, op_valid, flush;
  logic [5:0]   funct;
  logic [W-1:0] rs_data, rt_data;
  logic         stall, busy, done;
  logic [W-1:0] hi, lo, mf_data;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .funct(funct),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush), .stall(stall),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .mf_data(mf_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           issue_edge;
    int           lat;
  } exp_t;

  exp_t         sb_q[$];
  int           n_chk  = 0;
  int           n_fail = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic calc(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                      output logic [W-1:0] eh, output logic [W-1:0] el);
    longint       sa, sb;
    logic [63:0]  p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = '0;
    el = '0;
    if (f == F_MULT) begin
      p = sa * sb;
      {eh, el} = p;
    end else if (f == F_MULTU) begin
      p = {32'b0, a} * {32'b0, b};
      {eh, el} = p;
    end else if (b == '0) begin
      eh = a;
      el = '1;
    end else if (f == F_DIV) begin
      q = sa / sb;
      r = sa % sb;
      eh = r[W-1:0];
      el = q[W-1:0];
    end else begin
      q = {32'b0, a} / {32'b0, b};
      r = {32'b0, a} % {32'b0, b};
      eh = r[W-1:0];
      el = q[W-1:0];
    end
  endtask

  function automatic int exp_lat(input logic [5:0] f, input logic [W-1:0] b);
    logic [W-1:0] mag;
    int           steps;
    if (f == F_DIV || f == F_DIVU) return (b == '0) ? 0 : W + 2;
    mag   = (f == F_MULT && b[W-1]) ? -b : b;
    steps = W;
`ifdef MULDIV_EARLY_EXIT_EN
    steps = 1;
    for (int i = 0; i < W; i++) if (mag[i]) steps = i + 1;
`endif
    return steps + 2;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("result_hi", 64'(hi), 64'(e.hi));
        chk("result_lo", 64'(lo), 64'(e.lo));
        chk("latency", 64'(cyc - e.issue_edge), 64'(e.lat));
      end
    end
  end

  // Present an instruction at a negedge, hold it through any stall, then retire it.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit track);
    int           n;
    exp_t         e;
    logic [W-1:0] eh, el;
    op_valid = 1'b1;
    funct    = f;
    rs_data  = a;
    rt_data  = b;
    #1;
    n = 0;
    while (stall && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (stall) chk("stall_timeout", 64'(stall), 64'd0);
    if (f == F_MFHI)      chk("mfhi_data", 64'(mf_data), 64'(m_hi));
    else if (f == F_MFLO) chk("mflo_data", 64'(mf_data), 64'(m_lo));
    else                  chk("mf_idle_zero", 64'(mf_data), 64'd0);
    if (f == F_MTHI) m_hi = a;
    if (f == F_MTLO) m_lo = a;
    if (is_md_funct(f) && track) begin
      calc(f, a, b, eh, el);
      e.hi = eh;
      e.lo = el;
      e.issue_edge = cyc + 1;
      e.lat = exp_lat(f, b);
      sb_q.push_back(e);
      m_hi = eh;
      m_lo = el;
    end
    @(negedge clk);
    op_valid = 1'b0;
    funct    = 6'b100000;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drain", 64'(sb_q.size()), 64'd0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return W'($urandom_range(0, 20)) - W'(10);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0] md_f [4];
    md_f[0] = F_MULT; md_f[1] = F_MULTU; md_f[2] = F_DIV; md_f[3] = F_DIVU;

    reset = 1'b1; op_valid = 1'b0; flush = 1'b0;
    funct = 6'b100000; rs_data = '0; rt_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    @(negedge clk);

    // Directed corner cases
    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    issue(F_MULT,  -32'sd7, 32'd3, 1);
    issue(F_DIV,   -32'sd7, 32'd2, 1);
    issue(F_DIVU,  32'd100, 32'd0, 1);
    issue(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(F_MULTU, 32'd5, 32'd1, 1);
    issue(F_MFHI, '0, '0, 1);
    issue(F_MFLO, '0, '0, 1);
    drain();

    // MULT then MFLO next cycle; an unrelated instruction meanwhile is not stalled
    issue(F_MULT, 32'd123457, -32'sd98765, 1);
    op_valid = 1'b1; funct = 6'b100000; #1;
    chk("add_not_stalled", 64'(stall), 64'd0);
    @(negedge clk);
    funct = F_MFLO; #1;
    chk("mflo_stalled", 64'(stall), 64'd1);
    issue(F_MFLO, '0, '0, 1);
    issue(F_MFHI, '0, '0, 1);

    // Randomized mix, back-to-back
    repeat (60) begin
      int r = $urandom_range(0, 9);
      if (r <= 5)      issue(md_f[$urandom_range(0, 3)], pick(), pick(), 1);
      else if (r == 6) issue(F_MTHI, $urandom, '0, 1);
      else if (r == 7) issue(F_MTLO, $urandom, '0, 1);
      else if (r == 8) issue(F_MFHI, '0, '0, 1);
      else             issue(F_MFLO, '0, '0, 1);
    end
    drain();

    // Flush mid-ITER: HI/LO keep MTHI/MTLO values, no done pulse
    issue(F_MTHI, 32'h1234, '0, 1);
    issue(F_MTLO, 32'h5678, '0, 1);
    issue(F_DIV, 32'd1000, 32'd7, 0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hi", 64'(hi), 64'h1234);
    chk("flush_lo", 64'(lo), 64'h5678);
    // Flush in IDLE squashes a same-cycle MTHI
    @(negedge clk);
    op_valid = 1'b1; funct = F_MTHI; rs_data = 32'hDEAD; flush = 1'b1;
    @(negedge clk);
    op_valid = 1'b0; flush = 1'b0; funct = 6'b100000;
    #1;
    chk("flush_idle_hi", 64'(hi), 64'h1234);
    repeat (40) @(negedge clk);

    // Reset mid-ITER clears HI/LO and busy
    issue(F_MULTU, 32'hABCD, 32'h1357_9BDF, 0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    issue(F_MFHI, '0, '0, 1);
    issue(F_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 1);
    issue(F_DIVU, 32'hFFFF_FFFF, 32'd3, 1);
    issue(F_MFLO, '0, '0, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
